// File: rtl/generic_csa_tree.sv
// generic_csa_tree: pipelined multi-operand 3:2 carry-save reduction tree with optional registered final adder.
module generic_csa_tree #(
  parameter int DW_A      = 10,
  parameter int DW_B      = 10,
  parameter int N_OP      = 8,
  parameter int PIPE_LVL  = 1,
  parameter int FINAL_ADD = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_in_valid,
  output logic                           o_in_ready,
  input  logic [N_OP*(DW_A+DW_B)-1:0]    i_in_ops,
  output logic                           o_out_valid,
  input  logic                           i_out_ready,
  output logic [DW_A+DW_B-1:0]           o_csa_s,
  output logic [DW_A+DW_B-1:0]           o_csa_c,
  output logic [DW_A+DW_B-1:0]           o_sum_out
);
  localparam int W = DW_A + DW_B;
  function automatic int f_rows(input int k);
    int n;
    n = N_OP;
    for (int i = 0; i < k; i++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction
  function automatic int f_levels();
    int n, l;
    n = N_OP;
    l = 0;
    for (int i = 0; i < 16; i++) if (n > 2) begin n = 2 * (n / 3) + n % 3; l++; end
    return l;
  endfunction
  function automatic logic [W-1:0] f_carry(input logic [W-1:0] a, b, c);
    logic [W-1:0] m;
    m = (a & b) | (a & c) | (b & c);
    return {m[W-2:0], 1'b0};
  endfunction
  localparam int L = f_levels();
  if (N_OP < 3 || N_OP > 16) begin : g_bad
    $error("generic_csa_tree: N_OP must be within 3..16");
  end
  logic [N_OP-1:0][W-1:0] w_lv [0:L];
  logic                   w_v  [0:L];
  logic                   w_adv;
  assign w_adv      = !o_out_valid | i_out_ready;
  assign o_in_ready = w_adv;
  assign w_lv[0]    = i_in_ops;
  assign w_v[0]     = i_in_valid;
  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int NI = f_rows(k - 1);
    localparam int NG = NI / 3;
    logic [N_OP-1:0][W-1:0] w_nx;
    always_comb begin
      w_nx = '0;
      for (int g = 0; g < NG; g++) begin
        w_nx[2*g]   = w_lv[k-1][3*g] ^ w_lv[k-1][3*g+1] ^ w_lv[k-1][3*g+2];
        w_nx[2*g+1] = f_carry(w_lv[k-1][3*g], w_lv[k-1][3*g+1], w_lv[k-1][3*g+2]);
      end
      for (int j = 0; j < NI % 3; j++) w_nx[2*NG+j] = w_lv[k-1][3*NG+j];
    end
    if (k == L || (PIPE_LVL > 0 && k % PIPE_LVL == 0)) begin : g_reg
      logic [N_OP-1:0][W-1:0] r_d;
      logic                   r_v;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_d <= '0;
          r_v <= 1'b0;
        end else if (w_adv) begin
          r_d <= w_nx;
          r_v <= w_v[k-1];
        end
      end
      assign w_lv[k] = r_d;
      assign w_v[k]  = r_v;
    end else begin : g_comb
      assign w_lv[k] = w_nx;
      assign w_v[k]  = w_v[k-1];
    end
  end
  if (FINAL_ADD != 0) begin : g_add
    logic [W-1:0] r_s, r_c, r_sum;
    logic         r_v;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_s   <= '0;
        r_c   <= '0;
        r_sum <= '0;
        r_v   <= 1'b0;
      end else if (w_adv) begin
        r_s   <= w_lv[L][0];
        r_c   <= w_lv[L][1];
        r_sum <= w_lv[L][0] + w_lv[L][1];
        r_v   <= w_v[L];
      end
    end
    assign o_csa_s     = r_s;
    assign o_csa_c     = r_c;
    assign o_sum_out   = r_sum;
    assign o_out_valid = r_v;
  end else begin : g_noadd
    assign o_csa_s     = w_lv[L][0];
    assign o_csa_c     = w_lv[L][1];
    assign o_sum_out   = '0;
    assign o_out_valid = w_v[L];
  end
endmodule

// File: doc/generic_csa_tree.md
Name: generic_csa_tree

Overview:
Parametrised, pipelined carry-save reduction tree. Compresses N_OP operands of width DW_A+DW_B into one sum/carry pair using layered 3:2 CSA levels. Optionally resolves the pair with a final carry-propagate adder. It is the multi-operand successor of the single 3:2 CSA stage and feeds partial-product reduction in the FP multiplier mantissa datapath. Valid/ready handshake with full-pipeline stall supports backpressure.

Parameters:
DW_A, 10, operand A width contribution; W = DW_A+DW_B is the datapath width
DW_B, 10, operand B width contribution
N_OP, 8, number of input operands, legal 3..16
PIPE_LVL, 1, register after every PIPE_LVL CSA levels; 0 = only output register
FINAL_ADD, 1, 1 = add registered CPA stage producing sum_out; 0 = sum_out tied 0

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input operands valid
in_ready  out  1  block accepts input this cycle
in_ops  in  N_OP*W  operand i at bits [i*W +: W]
out_valid  out  1  outputs valid
out_ready  in  1  downstream accepts output
csa_s  out  W  redundant sum vector
csa_c  out  W  redundant carry vector, already left-shifted
sum_out  out  W  (csa_s+csa_c) mod 2^W when FINAL_ADD=1, else 0

Behaviour:
- CSA level: each group of 3 rows gives s = a^b^c and c = maj(a,b,c)<<1, with the carry MSB discarded and LSB 0. Leftover 1-2 rows pass through unchanged. Row count n -> 2*floor(n/3) + n mod 3. Reduction stops at 2 rows.
- L = number of levels; N_OP=3 gives L=1, N_OP=8 gives L=4 (8->6->4->3->2), N_OP=16 gives L=6.
- Pipeline registers sit after level k for every k that is a multiple of PIPE_LVL, k<L. The final level output is always registered.
- Tree latency T = ceil(L/PIPE_LVL) when PIPE_LVL>0, else 1.
- Total latency LAT = T + FINAL_ADD cycles from accepted input to out_valid.
- csa_s/csa_c are delayed alongside sum_out so all three outputs belong to the same transaction.
- Arithmetic is modulo 2^W throughout. Invariant: (csa_s+csa_c) mod 2^W = (sum of operands) mod 2^W.
- Each stage carries a valid bit. advance = !out_valid | out_ready. in_ready = advance (combinational).
- When advance=1, all stages shift by one; stage 0 loads in_ops with valid = in_valid.
- When advance=0, all stage data and valid bits hold; in_valid is ignored.
- Bubbles propagate as valid=0 stages. Data in invalid stages is don't-care, but outputs must not change while out_valid=1 and out_ready=0.
- Throughput is one transaction per cycle when out_ready is held 1.
- Reset: all stage valid bits, out_valid, csa_s, csa_c and sum_out are cleared to 0. In-flight transactions are discarded; a transaction accepted in the rst cycle is dropped. in_ready = 1 during and after reset, since out_valid=0.
- Simultaneous out_valid&out_ready and in_valid&in_ready: output retires and input is accepted in the same cycle; no bubble.
- N_OP<3 or N_OP>16 is rejected at elaboration.

Test Plan:
- DW_A=DW_B=4, N_OP=8, PIPE_LVL=1, FINAL_ADD=1; in_ops = 1..8 (op0=1) with out_ready=1 -> out_valid exactly 5 cycles later, sum_out=0x24, (csa_s+csa_c) mod 256 = 0x24.
- Overflow: same config, all operands 0xFF -> sum_out=0xF8. Carry MSB dropped; csa_c bit0 = 0.
- Back-to-back stream of 20 random vectors, out_ready random 50% -> every output matches a scoreboard in order, no loss or duplication. Outputs hold stable while stalled; in_ready equals !out_valid|out_ready every cycle.
- N_OP=3, PIPE_LVL=0, FINAL_ADD=0; operands 0x05,0x03,0x06 -> 1-cycle latency, csa_s=0x00, csa_c=0x0E, sum_out=0. Matches a single 3:2 stage.
- Fill the pipeline with 5 valid transactions, assert rst one cycle -> next cycle out_valid=0, all outputs 0, no stale transaction ever emerges. New input after reset completes with the full latency.
- N_OP=16, PIPE_LVL=2, FINAL_ADD=1, W=20; operands 0x0000F..0x0001E -> LAT=4 (L=6, T=3), sum_out = 0x00168 (sum 15..30 = 360).
